// File: rtl/pwm_dt_pkg.sv
// Shared types for the PWM dead-time output stage: FSM encoding, output decode, defaults.
package pwm_dt_pkg;

  localparam int DTW_DEF     = 8;
  localparam int FLT_LEN_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DT_R  = 3'd1,
    HI    = 3'd2,
    DT_F  = 3'd3,
    LO    = 3'd4,
    FAULT = 3'd5
  } pwm_state_e;

  // Logical (pre-polarity) drive levels for one state.
  typedef struct packed {
    logic hi;
    logic lo;
    logic busy;
    logic flt;
  } drv_t;

  function automatic drv_t drv_decode(pwm_state_e s);
    drv_t d;
    d      = '0;
    d.hi   = (s == HI);
    d.lo   = (s == LO);
    d.busy = (s == DT_R) || (s == DT_F);
    d.flt  = (s == FAULT);
    return d;
  endfunction

endpackage

// File: rtl/pwm_fault_sync.sv
// Two-flop fault synchroniser; with PWM_FAULT_FILTER_EN defined, fault must stay
// high for FLT_LEN consecutive synchronised samples before flt_sync asserts.
module pwm_fault_sync
  import pwm_dt_pkg::*;
#(
  parameter int FLT_LEN = FLT_LEN_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fault_i,
  output logic flt_sync
);

  logic s1, s2;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= fault_i;
      s2 <= s1;
    end
  end

`ifdef PWM_FAULT_FILTER_EN
  localparam int CW = $clog2(FLT_LEN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(FLT_LEN - 1);

  // Counts consecutive high samples beyond the first; saturates at RUN_MAX.
  logic [CW-1:0] run_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)              run_q <= '0;
    else if (!s2)             run_q <= '0;
    else if (run_q != RUN_MAX) run_q <= run_q + 1'b1;
  end

  assign flt_sync = s2 && (run_q == RUN_MAX);
`else
  assign flt_sync = s2;
`endif

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM gate-drive stage with programmable dead time and latched fault.
// Build option: PWM_FAULT_FILTER_EN enables the FLT_LEN-cycle fault filter.
module pwm_deadtime_gen
  import pwm_dt_pkg::*;
#(
  parameter int   DTW     = DTW_DEF,
  parameter logic SAFE_HI = 1'b0,
  parameter logic SAFE_LO = 1'b0,
  parameter int   FLT_LEN = FLT_LEN_DEF
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  input  logic           pwm_i,
  input  logic [DTW-1:0] dt_rise_i,
  input  logic [DTW-1:0] dt_fall_i,
  input  logic [1:0]     pol_i,
  input  logic           fault_i,
  input  logic           fault_clr_i,
  output logic           pwm_hi_o,
  output logic           pwm_lo_o,
  output logic           fault_o,
  output logic           dt_busy_o
);

  pwm_state_e     state_q, state_d;
  logic [DTW-1:0] cnt_q, cnt_d;
  logic           pwm_q;
  logic           flt_sync;
  drv_t           drv;

  pwm_fault_sync #(.FLT_LEN(FLT_LEN)) u_fault_sync (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .fault_i  (fault_i),
    .flt_sync (flt_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (state_q == FAULT) begin
      if (fault_clr_i && !flt_sync) state_d = IDLE;
    end else if (flt_sync) begin
      state_d = FAULT;
    end else if (!en_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pwm_q) begin state_d = DT_R; cnt_d = dt_rise_i; end
          else       begin state_d = DT_F; cnt_d = dt_fall_i; end
        end
        // A reversal during dead time jumps straight to the side that was
        // already off, so no overlap is possible.
        DT_R: begin
          if (!pwm_q)            state_d = LO;
          else if (cnt_q == '0)  state_d = HI;
          else                   cnt_d   = cnt_q - 1'b1;
        end
        HI: if (!pwm_q) begin state_d = DT_F; cnt_d = dt_fall_i; end
        DT_F: begin
          if (pwm_q)             state_d = HI;
          else if (cnt_q == '0)  state_d = LO;
          else                   cnt_d   = cnt_q - 1'b1;
        end
        LO: if (pwm_q) begin state_d = DT_R; cnt_d = dt_rise_i; end
        default: state_d = IDLE;
      endcase
    end
  end

  assign drv = drv_decode(state_d);

  // Outputs are registered from the next state so pads move with the state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pwm_q     <= 1'b0;
      pwm_hi_o  <= 1'b0;
      pwm_lo_o  <= 1'b0;
      fault_o   <= 1'b0;
      dt_busy_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_i;
      fault_o   <= drv.flt;
      dt_busy_o <= drv.busy;
      if (drv.flt) begin
        pwm_hi_o <= SAFE_HI;
        pwm_lo_o <= SAFE_LO;
      end else begin
        pwm_hi_o <= drv.hi ^ pol_i[1];
        pwm_lo_o <= drv.lo ^ pol_i[0];
      end
    end
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Bench for pwm_deadtime_gen: directed scenarios plus randomized traffic against a
// timestamp-based reference model. Define PWM_FAULT_FILTER_EN to cover the filter.
module tb_pwm_deadtime_gen;

  localparam logic SAFE_HI = 1'b0;
  localparam logic SAFE_LO = 1'b0;
`ifdef PWM_FAULT_FILTER_EN
  localparam int FLT = 4;
`else
  localparam int FLT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n, en, pwm, fault, fault_clr;
  logic [7:0] dt_rise, dt_fall;
  logic [1:0] pol;
  logic       hi_o, lo_o, flt_o, busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: which side is targeted, and the cycle after which it drives.
  int        cyc = 0;
  bit        m_pq;
  bit [15:0] fhist;
  bit        faulted, engaged, side;
  int        deadline;
  logic      e_hi, e_lo, e_flt, e_busy;

  pwm_deadtime_gen #(.DTW(8), .SAFE_HI(SAFE_HI), .SAFE_LO(SAFE_LO), .FLT_LEN(4)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .pwm_i       (pwm),
    .dt_rise_i   (dt_rise),
    .dt_fall_i   (dt_fall),
    .pol_i       (pol),
    .fault_i     (fault),
    .fault_clr_i (fault_clr),
    .pwm_hi_o    (hi_o),
    .pwm_lo_o    (lo_o),
    .fault_o     (flt_o),
    .dt_busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit fs, on;
    cyc++;
    if (!rst_n) begin
      m_pq = 0; fhist = '0; faulted = 0; engaged = 0; side = 0; deadline = 0;
      e_hi = 0; e_lo = 0; e_flt = 0; e_busy = 0;
      return;
    end
    // Synchronised fault: the last FLT samples, each at least two edges old, all high.
    fs = 1'b1;
    for (int i = 1; i <= FLT; i++) fs &= fhist[i];
    if (faulted) begin
      if (fault_clr && !fs) begin faulted = 0; engaged = 0; end
    end else if (fs) begin
      faulted = 1;
    end else if (!en) begin
      engaged = 0;
    end else if (!engaged) begin
      engaged  = 1;
      side     = m_pq;
      deadline = cyc + (m_pq ? int'(dt_rise) : int'(dt_fall)) + 1;
    end else if (m_pq != side) begin
      if (deadline >= cyc) deadline = cyc;
      else deadline = cyc + (m_pq ? int'(dt_rise) : int'(dt_fall)) + 1;
      side = m_pq;
    end
    m_pq  = pwm;
    fhist = {fhist[14:0], fault};
    on     = engaged && (cyc >= deadline);
    e_flt  = faulted;
    e_busy = !faulted && engaged && (cyc < deadline);
    e_hi   = faulted ? SAFE_HI : ((on && side) ^ pol[1]);
    e_lo   = faulted ? SAFE_LO : ((on && !side) ^ pol[0]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("hi", hi_o, e_hi);
    chk("lo", lo_o, e_lo);
    chk("fault", flt_o, e_flt);
    chk("busy", busy_o, e_busy);
    if (pol == 2'b00 && !e_flt) chk("overlap", hi_o & lo_o, 0);
  endtask

  initial begin
    int nb, nh, nl, hold, fpulse;
    rst_n = 0; en = 0; pwm = 0; fault = 0; fault_clr = 0;
    dt_rise = 8'd5; dt_fall = 8'd3; pol = 2'b00;
    @(negedge clk);
    tick(); tick();
    chk("rst_hi", hi_o, 0); chk("rst_lo", lo_o, 0);
    chk("rst_flt", flt_o, 0); chk("rst_busy", busy_o, 0);

    rst_n = 1; en = 1;
    repeat (8) tick();
    chk("settle_lo", lo_o, 1);

    // 1: rise with dt_rise=5
    pwm = 1; tick();         // edge N
    tick();                  // edge N+1
    chk("t1_lo_off", lo_o, 0);
    nb = busy_o ? 1 : 0;
    repeat (5) begin tick(); chk("t1_hi_off", hi_o, 0); nb += busy_o ? 1 : 0; end
    tick();                  // edge N+7
    chk("t1_hi_on", hi_o, 1);
    chk("t1_busy_len", nb, 6);

    // 2: fall with dt_fall=0
    dt_fall = 8'd0; pwm = 0; tick(); tick();
    chk("t2_hi_off", hi_o, 0); chk("t2_lo_off", lo_o, 0);
    tick();
    chk("t2_lo_on", lo_o, 1);

    // 3: short high pulse shorter than dt_rise
    dt_rise = 8'd10; repeat (3) tick();
    nh = 0; nl = 0;
    pwm = 1; tick(); tick();
    nl += lo_o ? 0 : 1;
    pwm = 0;
    repeat (6) begin tick(); nh += hi_o ? 1 : 0; nl += lo_o ? 0 : 1; end
    chk("t3_hi_never", nh, 0); chk("t3_lo_off_len", nl, 2); chk("t3_no_fault", flt_o, 0);

    // 4: fault while in HI
    dt_rise = 8'd2; pwm = 1; repeat (6) tick();
    chk("t4_in_hi", hi_o, 1);
    fault = 1;
    repeat (FLT) tick();
    fault = 0; tick(); tick();
    chk("t4_fault", flt_o, 1); chk("t4_safe_hi", hi_o, SAFE_HI); chk("t4_safe_lo", lo_o, SAFE_LO);
    fault = 1; repeat (FLT + 3) tick();
    fault_clr = 1; tick(); fault_clr = 0;
    chk("t4_clr_blocked", flt_o, 1);
    fault = 0; repeat (4) tick();
    chk("t4_still_latched", flt_o, 1);
    fault_clr = 1; tick(); fault_clr = 0;
    chk("t4_cleared", flt_o, 0);
    repeat (6) tick();

`ifdef PWM_FAULT_FILTER_EN
    // 5: filter rejects a 3-cycle pulse, accepts 4
    fault = 1; repeat (3) tick(); fault = 0; repeat (8) tick();
    chk("t5_short_ignored", flt_o, 0);
    fault = 1; repeat (4) tick(); fault = 0; repeat (4) tick();
    chk("t5_long_latched", flt_o, 1);
    fault_clr = 1; tick(); fault_clr = 0; repeat (4) tick();
`endif

    // 6: reset during DT_R, then polarity inversion in IDLE
    pwm = 0; repeat (4) tick();
    dt_rise = 8'd20; pwm = 1; repeat (4) tick();
    chk("t6_in_dtr", busy_o, 1);
    rst_n = 0; pol = 2'b11; tick();
    chk("t6_rst_hi", hi_o, 0); chk("t6_rst_lo", lo_o, 0); chk("t6_rst_busy", busy_o, 0);
    rst_n = 1; en = 0; tick(); tick();
    chk("t6_idle_hi", hi_o, 1); chk("t6_idle_lo", lo_o, 1);
    en = 1; pol = 2'b00; dt_rise = 8'd3; repeat (6) tick();

    // Randomized traffic against the model
    hold = 0; fpulse = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin pwm = ~pwm; hold = $urandom_range(1, 12); end
      else hold--;
      if ($urandom_range(0, 9) == 0) dt_rise = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) dt_fall = 8'($urandom_range(0, 7));
      en = ($urandom_range(0, 99) >= 3);
      if (fpulse > 0) begin fault = 1; fpulse--; end
      else begin
        fault = 0;
        if ($urandom_range(0, 149) == 0) fpulse = $urandom_range(1, 6);
      end
      fault_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) pol = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
